// File: rtl/div_pkg.sv
// Shared definitions for the divider result BCD converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

   localparam int DIV_WIDTH  = 8;   // binary width of quotient/remainder
   localparam int DIV_DIGITS = 3;   // BCD digits per value, 10^3 > 255
   localparam int DIV_CNT_W  = $clog2(DIV_WIDTH + 1);  // iteration counter width

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   bcd_i / bin_i : current BCD accumulator and remaining binary bits
//   bcd_o / bin_o : accumulator and binary after this iteration
module bcd_dabble_step #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic [4*D-1:0] bcd_i,
   input  logic [W-1:0]   bin_i,
   output logic [4*D-1:0] bcd_o,
   output logic [W-1:0]   bin_o
);

   logic [4*D+W-1:0] acc_in;
   logic [4*D+W-1:0] acc_adj;
   logic [4*D+W-1:0] acc_sh;

   assign acc_in = {bcd_i, bin_i};

   always_comb begin
      acc_adj = acc_in;
      for (int i = 0; i < D; i++) begin
         // Nibbles are always <= 9 here, so +3 stays within 4 bits.
         if (acc_in[W + 4*i +: 4] >= 4'd5) begin
            acc_adj[W + 4*i +: 4] = acc_in[W + 4*i +: 4] + 4'd3;
         end
      end
   end

   // The MSB shifted out is always 0 because 10^D exceeds the binary range.
   assign acc_sh = acc_adj << 1;
   assign bcd_o  = acc_sh[4*D+W-1:W];
   assign bin_o  = acc_sh[W-1:0];

endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider quotient/remainder pair to packed BCD; divide-by-zero bypasses conversion as err.
// Latency: WIDTH+1 cycles from accept to out_valid (1 cycle for div_zero); one result per WIDTH+2 cycles max.
// Backpressure: result held in DONE with outputs stable until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : upstream handshake carrying quotient, remainder, div_zero
//   out_valid/out_ready    : downstream handshake carrying q_bcd, r_bcd, err
//   q_bcd, r_bcd           : packed BCD, digit 0 in [3:0]
//   err                    : result came from a divide-by-zero
module div_result_bcd
   import div_pkg::*;
#(
   parameter int WIDTH  = DIV_WIDTH,
   parameter int DIGITS = DIV_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      quotient,
   input  logic [WIDTH-1:0]      remainder,
   input  logic                  div_zero,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   q_bcd,
   output logic [4*DIGITS-1:0]   r_bcd,
   output logic                  err
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   q_bin;
   logic [WIDTH-1:0]   r_bin;
   logic [BCD_W-1:0]   q_acc;
   logic [BCD_W-1:0]   r_acc;
   logic [WIDTH-1:0]   q_bin_nx;
   logic [WIDTH-1:0]   r_bin_nx;
   logic [BCD_W-1:0]   q_acc_nx;
   logic [BCD_W-1:0]   r_acc_nx;

   bcd_dabble_step #(.W(WIDTH), .D(DIGITS)) u_q_step (
      .bcd_i (q_acc),
      .bin_i (q_bin),
      .bcd_o (q_acc_nx),
      .bin_o (q_bin_nx)
   );

   bcd_dabble_step #(.W(WIDTH), .D(DIGITS)) u_r_step (
      .bcd_i (r_acc),
      .bin_i (r_bin),
      .bcd_o (r_acc_nx),
      .bin_o (r_bin_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         q_bin <= '0;
         r_bin <= '0;
         q_acc <= '0;
         r_acc <= '0;
         q_bcd <= '0;
         r_bcd <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  q_bin <= quotient;
                  r_bin <= remainder;
                  q_acc <= '0;
                  r_acc <= '0;
                  cnt   <= CNT_W'(WIDTH);
                  if (div_zero) begin
                     q_bcd <= '0;
                     r_bcd <= '0;
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               q_bin <= q_bin_nx;
               r_bin <= r_bin_nx;
               q_acc <= q_acc_nx;
               r_acc <= r_acc_nx;
               cnt   <= cnt - CNT_W'(1);
               // Final iteration: publish this cycle's step result directly.
               if (cnt == CNT_W'(1)) begin
                  q_bcd <= q_acc_nx;
                  r_bcd <= r_acc_nx;
                  err   <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_div_result_bcd.sv
module tb_div_result_bcd;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        div_zero;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] q_bcd;
   logic [11:0] r_bcd;
   logic        err;

   int tests = 0;
   int fails = 0;

   div_result_bcd dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q_bcd     (q_bcd),
      .r_bcd     (r_bcd),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits by plain division.
   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] d2, d1, d0;
      d2 = 4'(v / 100);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
      return {d2, d1, d0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one input at a negedge; it is accepted at the following posedge (edge 0).
   task automatic send(input logic [7:0] q, input logic [7:0] r, input logic dz);
      @(negedge clk);
      in_valid  = 1'b1;
      quotient  = q;
      remainder = r;
      div_zero  = dz;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count negedges until out_valid (n=0 on timeout); flag in_ready seen high before that.
   task automatic wait_valid(output int n, output logic ir_seen);
      n = 0;
      ir_seen = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            n = i;
            break;
         end
         if (in_ready) ir_seen = 1'b1;
      end
   endtask

   initial begin
      int          n;
      logic        irs;
      int          ghost;
      logic [7:0]  rq, rr;
      logic        rdz;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      quotient  = '0;
      remainder = '0;
      div_zero  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_q_bcd",     32'(q_bcd),     32'd0);
      check("rst_r_bcd",     32'(r_bcd),     32'd0);
      check("rst_err",       32'(err),       32'd0);
      rst_n = 1'b1;

      // 255 / 0 : full-scale quotient
      send(8'd255, 8'd0, 1'b0);
      wait_valid(n, irs);
      check("t1_latency", 32'(n), 32'd9);
      check("t1_q",   32'(q_bcd), 32'h255);
      check("t1_r",   32'(r_bcd), 32'h000);
      check("t1_err", 32'(err),   32'd0);
      check("t1_in_ready_low", 32'(irs), 32'd0);
      @(negedge clk);
      check("t1_ov_after", 32'(out_valid), 32'd0);
      check("t1_ir_after", 32'(in_ready),  32'd1);

      // 42 / 7
      send(8'd42, 8'd7, 1'b0);
      wait_valid(n, irs);
      check("t2_latency", 32'(n), 32'd9);
      check("t2_q", 32'(q_bcd), 32'h042);
      check("t2_r", 32'(r_bcd), 32'h007);
      check("t2_in_ready_low", 32'(irs), 32'd0);
      @(negedge clk);
      check("t2_ir_cycle10", 32'(in_ready), 32'd1);

      // divide by zero bypass
      send(8'd99, 8'd5, 1'b1);
      wait_valid(n, irs);
      check("t3_latency", 32'(n), 32'd1);
      check("t3_q",   32'(q_bcd), 32'h000);
      check("t3_r",   32'(r_bcd), 32'h000);
      check("t3_err", 32'(err),   32'd1);
      @(negedge clk);
      check("t3_ir_after", 32'(in_ready), 32'd1);

      // backpressure
      out_ready = 1'b0;
      send(8'd128, 8'd199, 1'b0);
      wait_valid(n, irs);
      check("t4_latency", 32'(n), 32'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_ov", 32'(out_valid), 32'd1);
         check("t4_hold_q",  32'(q_bcd),     32'h128);
         check("t4_hold_r",  32'(r_bcd),     32'h199);
         check("t4_hold_ir", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_ov_released", 32'(out_valid), 32'd0);
      check("t4_ir_released", 32'(in_ready),  32'd1);

      // in_valid during SHIFT is ignored
      send(8'd100, 8'd50, 1'b0);
      repeat (2) @(negedge clk);
      in_valid  = 1'b1;
      quotient  = 8'd7;
      remainder = 8'd8;
      div_zero  = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      div_zero = 1'b0;
      wait_valid(n, irs);
      check("t5_latency", 32'(n), 32'd5);
      check("t5_q",   32'(q_bcd), 32'h100);
      check("t5_r",   32'(r_bcd), 32'h050);
      check("t5_err", 32'(err),   32'd0);
      @(negedge clk);
      check("t5_no_second", 32'(out_valid), 32'd0);

      // reset in the middle of SHIFT
      send(8'd200, 8'd17, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rst_q",  32'(q_bcd),     32'd0);
      check("t6_rst_r",  32'(r_bcd),     32'd0);
      check("t6_rst_err", 32'(err),      32'd0);
      check("t6_rst_ir", 32'(in_ready),  32'd1);
      check("t6_rst_ov", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ghost = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) ghost++;
      end
      check("t6_no_partial", 32'(ghost), 32'd0);
      send(8'd10, 8'd3, 1'b0);
      wait_valid(n, irs);
      check("t6_latency", 32'(n), 32'd9);
      check("t6_q", 32'(q_bcd), 32'h010);
      check("t6_r", 32'(r_bcd), 32'h003);

      // randomized against the decimal model
      for (int k = 0; k < 24; k++) begin
         rq  = 8'($urandom_range(0, 255));
         rr  = 8'($urandom_range(0, 255));
         rdz = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         check("rnd_ir_ready", 32'(in_ready), 32'd1);
         send(rq, rr, rdz);
         wait_valid(n, irs);
         check("rnd_latency", 32'(n), rdz ? 32'd1 : 32'd9);
         check("rnd_q",   32'(q_bcd), rdz ? 32'd0 : 32'(to_bcd(int'(rq))));
         check("rnd_r",   32'(r_bcd), rdz ? 32'd0 : 32'(to_bcd(int'(rr))));
         check("rnd_err", 32'(err),   32'(rdz));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
